// File: rtl/aes_inv_cntx.sv
// Sequencing control for an iterative AES decryptor: a forward key-expansion
// phase followed by eleven decryption steps, delayed through N matched stages.
module aes_inv_cntx #(
   parameter int N = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       start,
   output logic       accept,
   output logic [3:0] rndNo,
   output logic [3:0] keyNo,
   output logic       enbISR,
   output logic       enbISB,
   output logic       enbIMC,
   output logic       enbAR,
   output logic       enbKS,
   output logic       enbIKS,
   output logic       done,
   output logic [9:0] completed_round
);

   typedef enum logic {KEXP = 1'b0, DEC = 1'b1} phase_t;

   typedef struct packed {
      phase_t     phase;
      logic [3:0] cnt;
      logic       done;
   } stage_t;

   localparam stage_t RST_STAGE = '{phase: KEXP, cnt: 4'd0, done: 1'b0};

   stage_t r_stage [0:N-1];
   stage_t w_next;
   stage_t w_out;

   // Stage 0 is the sequence state; later stages only delay it so the
   // control lines line up with a pipelined datapath.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < N; i++) r_stage[i] <= RST_STAGE;
      end else if (start) begin
         r_stage[0] <= w_next;
         for (int i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   always_comb begin
      w_next      = r_stage[0];
      w_next.done = 1'b0;
      case (r_stage[0].phase)
         KEXP: begin
            if (r_stage[0].cnt >= 4'd9) begin
               w_next.phase = DEC;
               w_next.cnt   = 4'd0;
            end else begin
               w_next.cnt = r_stage[0].cnt + 4'd1;
            end
         end
         DEC: begin
            if (r_stage[0].cnt >= 4'd10) begin
               w_next.phase = KEXP;
               w_next.cnt   = 4'd0;
               w_next.done  = 1'b1;
            end else begin
               w_next.cnt = r_stage[0].cnt + 4'd1;
            end
         end
         default: w_next = RST_STAGE;
      endcase
   end

   assign w_out = r_stage[N-1];

   always_comb begin
      accept          = 1'b0;
      rndNo           = 4'd0;
      keyNo           = w_out.cnt + 4'd1;
      enbISR          = 1'b0;
      enbISB          = 1'b0;
      enbIMC          = 1'b0;
      enbAR           = 1'b0;
      enbKS           = 1'b0;
      enbIKS          = 1'b0;
      done            = w_out.done;
      completed_round = 10'd0;
      if (w_out.phase == DEC) begin
         accept = (w_out.cnt == 4'd0);
         rndNo  = w_out.cnt;
         keyNo  = 4'd10 - w_out.cnt;
         enbAR  = 1'b1;
         enbISR = (w_out.cnt != 4'd0);
         enbISB = (w_out.cnt != 4'd0);
         enbIMC = (w_out.cnt != 4'd0) && (w_out.cnt <= 4'd9);
         enbIKS = (w_out.cnt <= 4'd9);
         if (w_out.cnt != 4'd0) completed_round = 10'd1 << (w_out.cnt - 4'd1);
      end else begin
         enbKS = 1'b1;
      end
   end

endmodule

// File: tb/tb_aes_inv_cntx.sv
// Bench for aes_inv_cntx: N=4 and N=1 instances share stimulus and are checked
// every cycle against an index-based model, plus pinned literal expectations.
module tb_aes_inv_cntx;

   logic clk = 1'b0;
   logic rstn = 1'b1;
   logic start = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   int k = 0;

   logic       acc4, acc1, isr4, isr1, isb4, isb1, imc4, imc1;
   logic       ar4, ar1, ks4, ks1, iks4, iks1, dn4, dn1;
   logic [3:0] rnd4, rnd1, key4, key1;
   logic [9:0] cr4, cr1;
   logic [25:0] got4, got1, snap4, snap1;

   always #5 clk = ~clk;

   aes_inv_cntx #(.N(4)) dut4 (
      .clk(clk), .rstn(rstn), .start(start), .accept(acc4), .rndNo(rnd4),
      .keyNo(key4), .enbISR(isr4), .enbISB(isb4), .enbIMC(imc4), .enbAR(ar4),
      .enbKS(ks4), .enbIKS(iks4), .done(dn4), .completed_round(cr4)
   );

   aes_inv_cntx #(.N(1)) dut1 (
      .clk(clk), .rstn(rstn), .start(start), .accept(acc1), .rndNo(rnd1),
      .keyNo(key1), .enbISR(isr1), .enbISB(isb1), .enbIMC(imc1), .enbAR(ar1),
      .enbKS(ks1), .enbIKS(iks1), .done(dn1), .completed_round(cr1)
   );

   assign got4 = {acc4, rnd4, key4, isr4, isb4, imc4, ar4, ks4, iks4, dn4, cr4};
   assign got1 = {acc1, rnd1, key1, isr1, isb1, imc1, ar1, ks1, iks1, dn1, cr1};

   // Number of advances since the last reset.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) k <= 0;
      else if (start) k <= k + 1;
   end

   // Output of an N-stage controller after k advances: the sequence index is
   // delayed by N-1 advances; done marks the first index after a full pass.
   function automatic logic [25:0] model(input int n, input int kk);
      int m, idx, c;
      logic dec, dn;
      logic [9:0] cr;
      m = kk - n + 1;
      if (m < 0) m = 0;
      idx = m % 21;
      dec = (idx >= 10);
      c   = dec ? idx - 10 : idx;
      dn  = (m > 0) && (m % 21 == 0);
      cr  = (dec && c >= 1) ? (10'd1 << (c - 1)) : 10'd0;
      return {dec && c == 0, dec ? 4'(c) : 4'd0, dec ? 4'(10 - c) : 4'(c + 1),
              dec && c >= 1, dec && c >= 1, dec && c >= 1 && c <= 9, dec, !dec,
              dec && c <= 9, dn, cr};
   endfunction

   always @(negedge clk) begin
      vectors++;
      if (got4 !== model(4, k)) begin
         miscompares++;
         $display("FAIL model_n4 k=%0d got=%h exp=%h", k, got4, model(4, k));
      end
      vectors++;
      if (got1 !== model(1, k)) begin
         miscompares++;
         $display("FAIL model_n1 k=%0d got=%h exp=%h", k, got1, model(1, k));
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reset output pattern: enbKS=1, keyNo=1, everything else 0.
   localparam logic [25:0] RST_VEC = {1'b0, 4'd0, 4'd1, 6'b000010, 1'b0, 10'd0};

   initial begin
      #1 rstn = 1'b0;
      #1;
      chk("reset_no_edge_n4", 32'(got4), 32'(RST_VEC));
      chk("reset_no_edge_n1", 32'(got1), 32'(RST_VEC));
      step(2);
      rstn  = 1'b1;
      start = 1'b1;

      step(10);
      chk("n1_e10_accept", 32'(acc1), 1);
      step(3);
      chk("e13_accept", 32'(acc4), 1);
      chk("e13_enbAR", 32'(ar4), 1);
      chk("e13_keyNo", 32'(key4), 10);
      step(1);
      chk("e14_enb", 32'({isr4, isb4, imc4, iks4}), 32'hF);
      chk("e14_cr", 32'(cr4), 32'h001);
      step(7);
      chk("n1_e21_done", 32'(dn1), 1);
      step(2);
      chk("e23_cr", 32'(cr4), 32'h200);
      chk("e23_enbIMC", 32'(imc4), 0);
      step(1);
      chk("e24_done", 32'(dn4), 1);
      chk("e24_enbKS", 32'(ks4), 1);
      chk("e24_keyNo", 32'(key4), 1);
      #3;
      chk("e24_done_hold", 32'(dn4), 1);
      step(1);
      chk("e25_done", 32'(dn4), 0);
      step(20);
      chk("e45_done", 32'(dn4), 1);

      // Stall for five cycles mid-sequence.
      step(6);
      start = 1'b0;
      snap4 = got4;
      snap1 = got1;
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("stall_n4", 32'(got4), 32'(snap4));
         chk("stall_n1", 32'(got1), 32'(snap1));
      end
      start = 1'b1;

      // Run to DEC C=5 on the N=4 output, then reset between edges.
      for (int i = 0; i < 30 && ((k - 3) % 21) != 15; i++) step(1);
      chk("reach_dec5_rnd", 32'(rnd4), 5);
      #2 rstn = 1'b0;
      #1;
      chk("midreset_n4", 32'(got4), 32'(RST_VEC));
      chk("midreset_n1", 32'(got1), 32'(RST_VEC));
      step(2);
      rstn = 1'b1;
      step(10);
      chk("post_reset_n1_e10_accept", 32'(acc1), 1);
      step(3);
      chk("post_reset_e13_accept", 32'(acc4), 1);

      // Randomised start with occasional resets.
      for (int i = 0; i < 600; i++) begin
         start = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) begin
            #1 rstn = 1'b0;
            #1 rstn = 1'b1;
         end
         step(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
